// File: rtl/waveform_generator_if.sv
// Sample-request / sample-output bundle between the strobe source, the waveform
// generator and the downstream datapath. offset_i exists only with WAVEGEN_OFFSET_EN.
interface waveform_generator_if #(
    parameter int N_FRAC = 7
);
    localparam int W = N_FRAC + 1;

    logic signed [W-1:0] phase_i;
    logic signed [W-1:0] threshold_i;
    logic        [1:0]   mode_i;
    logic                sync_i;
    logic                next_data_strobe_i;
`ifdef WAVEGEN_OFFSET_EN
    logic signed [W-1:0] offset_i;
`endif
    logic signed [W-1:0] data_o;
    logic                data_out_valid_strobe_o;

    modport master (
`ifdef WAVEGEN_OFFSET_EN
        output offset_i,
`endif
        output phase_i,
        output threshold_i,
        output mode_i,
        output sync_i,
        output next_data_strobe_i,
        input  data_o,
        input  data_out_valid_strobe_o
    );

    modport slave (
`ifdef WAVEGEN_OFFSET_EN
        input  offset_i,
`endif
        input  phase_i,
        input  threshold_i,
        input  mode_i,
        input  sync_i,
        input  next_data_strobe_i,
        output data_o,
        output data_out_valid_strobe_o
    );
endinterface

// File: rtl/waveform_generator.sv
// Multi-mode waveform source (square/sawtooth/triangle/zero) off a wrapping phase accumulator; WAVEGEN_OFFSET_EN adds a saturating DC offset.
// Latency: valid pulse 2 cycles after the strobe is sampled; one sample per strobe, strobe every cycle allowed.
// Backpressure: none; the consumer must accept every valid pulse, data_o holds between pulses.
module waveform_generator #(
    parameter int N_FRAC = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    waveform_generator_if.slave  bus
);
    localparam int W = N_FRAC + 1;

    localparam logic signed [W-1:0] ONE     = {1'b0, {N_FRAC{1'b1}}};
    localparam logic signed [W-1:0] NEG_ONE = {1'b1, {(N_FRAC-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {N_FRAC{1'b0}}};

    localparam logic signed [W+1:0] ONE_X2     = {3'b000, {N_FRAC{1'b1}}};
    localparam logic signed [W+1:0] NEG_ONE_X2 = -ONE_X2;
    localparam logic signed [W+1:0] HALF_X2    = {3'b001, {N_FRAC{1'b0}}};

    localparam logic [1:0] MODE_SQUARE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    // stage 1: accumulator and per-sample controls
    logic signed [W-1:0] acc;
    logic signed [W-1:0] thr_q;
    logic        [1:0]   mode_q;
    logic                v1;
`ifdef WAVEGEN_OFFSET_EN
    logic signed [W-1:0] off_q;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc    <= '0;
            thr_q  <= '0;
            mode_q <= '0;
            v1     <= 1'b0;
`ifdef WAVEGEN_OFFSET_EN
            off_q  <= '0;
`endif
        end else begin
            v1 <= bus.next_data_strobe_i;
            if (bus.next_data_strobe_i) begin
                // sync with a strobe restarts from zero and then takes one step
                acc    <= (bus.sync_i ? '0 : acc) + bus.phase_i;
                thr_q  <= bus.threshold_i;
                mode_q <= bus.mode_i;
`ifdef WAVEGEN_OFFSET_EN
                off_q  <= bus.offset_i;
`endif
            end else if (bus.sync_i) begin
                acc <= '0;
            end
        end
    end

    // waveform mapping from the stage-1 accumulator
    logic signed [W+1:0] acc_x2;
    logic signed [W+1:0] abs_x2;
    logic signed [W+1:0] tri_x2;
    logic signed [W-1:0] tri_sat;
    logic signed [W-1:0] wave;

    always_comb begin
        acc_x2 = {{2{acc[W-1]}}, acc};
        abs_x2 = acc[W-1] ? -acc_x2 : acc_x2;
        tri_x2 = {abs_x2[W:0], 1'b0} - HALF_X2;
        if (tri_x2 > ONE_X2) begin
            tri_sat = ONE;
        end else if (tri_x2 < NEG_ONE_X2) begin
            tri_sat = NEG_ONE;
        end else begin
            tri_sat = tri_x2[W-1:0];
        end

        case (mode_q)
            MODE_SQUARE: wave = (acc >= thr_q) ? ONE : NEG_ONE;
            MODE_SAW:    wave = (acc == MIN_VAL) ? NEG_ONE : acc;
            MODE_TRI:    wave = tri_sat;
            default:     wave = '0;
        endcase
    end

    logic signed [W-1:0] sample;

`ifdef WAVEGEN_OFFSET_EN
    logic signed [W:0] sum;
    localparam logic signed [W:0] ONE_X1     = {2'b00, {N_FRAC{1'b1}}};
    localparam logic signed [W:0] NEG_ONE_X1 = -ONE_X1;

    always_comb begin
        sum = {wave[W-1], wave} + {off_q[W-1], off_q};
        if (sum > ONE_X1) begin
            sample = ONE;
        end else if (sum < NEG_ONE_X1) begin
            sample = NEG_ONE;
        end else begin
            sample = sum[W-1:0];
        end
    end
`else
    assign sample = wave;
`endif

    // stage 2: registered output, updated only for a real sample
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.data_o                  <= '0;
            bus.data_out_valid_strobe_o <= 1'b0;
        end else begin
            bus.data_out_valid_strobe_o <= v1;
            if (v1) begin
                bus.data_o <= sample;
            end
        end
    end
endmodule

// File: tb/tb_waveform_generator.sv
// Directed bench for waveform_generator: integer reference model with a per-cycle compare,
// plus literal expected sample sequences for each scenario.
module tb_waveform_generator;
    localparam int N_FRAC = 7;
    localparam int W      = N_FRAC + 1;
    localparam int ONE    = (1 << N_FRAC) - 1;

    logic clk;
    logic rst_n;

    waveform_generator_if #(.N_FRAC(N_FRAC)) bus ();

    waveform_generator #(.N_FRAC(N_FRAC)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } smp_t;

    smp_t q[$];
    int   got[$];
    int   exp_q[$];
    int   m_acc;
    int   exp_dat;
    int   ecount;
    int   errors;
    int   checks;

    function automatic int wrap(input int v);
        int m;
        m = v & ((1 << W) - 1);
        return (m >= (1 << N_FRAC)) ? m - (1 << W) : m;
    endfunction

    function automatic int clamp(input int v);
        if (v > ONE) return ONE;
        if (v < -ONE) return -ONE;
        return v;
    endfunction

    function automatic int wave_of(input int a, input int mode, input int thr, input int off);
        int f;
        case (mode)
            0: f = (a >= thr) ? ONE : -ONE;
            1: f = clamp(a);
            2: f = clamp(2 * ((a < 0) ? -a : a) - (1 << N_FRAC));
            default: f = 0;
        endcase
        return clamp(f + off);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, req, ecount);
        end
    endtask

    task automatic model_flush();
        q.delete();
        m_acc   = 0;
        exp_dat = 0;
    endtask

    // reference model: sampled at each rising edge from the inputs held since the prior falling edge
    task automatic model_edge();
        int off;
        ecount++;
        if (!rst_n) return;
        off = 0;
`ifdef WAVEGEN_OFFSET_EN
        off = int'(bus.offset_i);
`endif
        if (bus.next_data_strobe_i) begin
            m_acc = wrap((bus.sync_i ? 0 : m_acc) + int'(bus.phase_i));
            q.push_back('{due: ecount + 1,
                          val: wave_of(m_acc, int'(bus.mode_i), int'(bus.threshold_i), off)});
        end else if (bus.sync_i) begin
            m_acc = 0;
        end
    endtask

    task automatic compare();
        int ev;
        ev = 0;
        if (q.size() > 0 && q[0].due == ecount) begin
            ev      = 1;
            exp_dat = q[0].val;
            void'(q.pop_front());
        end
        check("valid", int'(bus.data_out_valid_strobe_o), ev);
        check("data", int'(bus.data_o), exp_dat);
        if (bus.data_out_valid_strobe_o) got.push_back(int'(bus.data_o));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_s%0d", name, i), (i < got.size()) ? got[i] : 9999, exp_q[i]);
        end
        got.delete();
    endtask

    task automatic drive(input int strobe, input int sync, input int mode, input int phase);
        bus.next_data_strobe_i = strobe[0];
        bus.sync_i             = sync[0];
        bus.mode_i             = mode[1:0];
        bus.phase_i            = phase[W-1:0];
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ecount = 0;
        rst_n  = 1'b0;
        model_flush();
        drive(0, 0, 0, 0);
        bus.threshold_i = '0;
`ifdef WAVEGEN_OFFSET_EN
        bus.offset_i = '0;
`endif
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // square, strobe every 4 cycles
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 32);
            step();
            drive(0, 0, 0, 32);
            for (int j = 0; j < 3; j++) step();
        end
        exp_q = '{127, 127, 127, -127, -127};
        check_got("square");

        // sawtooth, back-to-back strobes from a synced zero
        drive(0, 1, 1, 64);
        step();
        drive(1, 0, 1, 64);
        for (int k = 0; k < 4; k++) step();
        drive(0, 0, 1, 64);
        step();
        step();
        exp_q = '{64, -127, -64, 0};
        check_got("saw");

        // triangle mapping and saturation
        drive(1, 0, 2, 64);
        for (int k = 0; k < 4; k++) step();
        drive(1, 0, 2, 127);
        step();
        drive(0, 0, 2, 127);
        step();
        step();
        exp_q = '{0, 127, 0, -127, 126};
        check_got("tri");

        // sync behaviour and in-flight mode change
        drive(1, 1, 0, 96);
        step();
        drive(1, 1, 0, 32);
        step();
        check("model_acc_sync", m_acc, 32);
        drive(0, 1, 0, 32);
        step();
        drive(1, 0, 0, 32);
        step();
        drive(1, 0, 0, 32);
        step();
        drive(0, 0, 3, 32);
        step();
        drive(1, 0, 3, 32);
        step();
        drive(0, 0, 3, 32);
        step();
        step();
        exp_q = '{127, 127, 127, 127, 0};
        check_got("sync_mode");

        // asynchronous reset between clock edges
        drive(1, 0, 1, 16);
        step();
        step();
        drive(0, 0, 1, 16);
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        model_flush();
        #1;
        check("arst_data", int'(bus.data_o), 0);
        check("arst_valid", int'(bus.data_out_valid_strobe_o), 0);
        @(negedge clk);
        compare();
        got.delete();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step();
        exp_q = '{};
        check_got("post_reset_idle");
        drive(1, 0, 1, 16);
        step();
        drive(0, 0, 1, 16);
        step();
        step();
        exp_q = '{16};
        check_got("post_reset");

`ifdef WAVEGEN_OFFSET_EN
        drive(0, 1, 1, 0);
        step();
        bus.offset_i = 8'sd64;
        drive(1, 0, 1, 96);
        step();
        bus.offset_i = -8'sd64;
        drive(1, 0, 1, 32);
        step();
        bus.offset_i = -8'sd20;
        drive(1, 0, 3, 32);
        step();
        drive(0, 0, 3, 32);
        step();
        step();
        exp_q = '{127, -127, -20};
        check_got("offset");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/waveform_generator.md
Name: waveform_generator

Overview:
Parametrised multi-mode waveform source. Successor to the single-mode square pulse block.
Owns a wrapping phase accumulator stepped by next_data_strobe_i. Produces square, sawtooth or triangle samples, or zero, in signed fixed point with a valid strobe. Sits between the sample-rate strobe source and the CORDIC/DAC datapath.

Parameters:
N_FRAC, 7, fractional bits; sample and phase width W = N_FRAC+1, signed Q0.N_FRAC
ONE, 2^N_FRAC-1 (derived localparam, not overridable), positive full scale; negative full scale is -ONE

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
phase_i  input  W  signed phase increment added per strobe
threshold_i  input  W  signed square-wave compare level
mode_i  input  2  00 square, 01 sawtooth, 10 triangle, 11 zero
sync_i  input  1  synchronous accumulator restart
next_data_strobe_i  input  1  one-cycle request for next sample
data_o  output  W  signed sample, registered
data_out_valid_strobe_o  output  1  one-cycle pulse, data_o updated

Behaviour:
- Reset (rst_i=0, asynchronous, no clock needed): accumulator 0; stage-1 regs 0; data_o=0; data_out_valid_strobe_o=0.
- Stage 1, registered:
  - On strobe: acc <= acc + phase_i, modulo 2^W (two's-complement wrap, no saturation).
  - Same edge: mode_i and threshold_i captured into stage-1 regs; v1 <= 1.
  - Otherwise v1 <= 0 and acc holds.
- sync_i handling:
  - sync_i=1, no strobe: acc <= 0, no valid.
  - sync_i=1 with strobe: acc <= phase_i (restart, then one step), v1 <= 1.
- Stage 2, registered, updates only when v1=1: data_o <= f(acc, captured mode/threshold); valid <= v1.
- Latency: valid pulse 2 cycles after strobe edge. data_o holds its last value between pulses.
- Strobe every cycle is legal. Throughput is 1 sample/cycle; every strobe yields exactly one valid pulse.
- f, with a = stage-1 accumulator value:
  - square: a >= threshold_i (signed) -> ONE, else -ONE.
  - sawtooth: a, except a = -2^N_FRAC -> -ONE (symmetric range).
  - triangle: t = 2*|a| - 2^N_FRAC, computed in W+2 bits (|-2^N_FRAC| = 2^N_FRAC is exact). Saturate t to [-ONE, ONE].
  - zero: 0, valid still pulses.
- All outputs are always within [-ONE, ONE]; -2^N_FRAC never appears on data_o.
- mode_i or threshold_i changes between strobes affect only later samples, never a sample in flight.
- Reset asserted mid-pipeline: in-flight samples are dropped, no valid pulse after release until a new strobe.

Optional Feature:
WAVEGEN_OFFSET_EN
- Defined:
  - Adds input offset_i, W bits, signed DC offset, captured with the strobe.
  - data_o = sat(f + offset_i) to [-ONE, ONE], computed in W+1 bits.
  - Latency unchanged; applies to all modes, including zero (which outputs the offset).
- Undefined: no offset_i port; data_o = f. Port list and timing are otherwise identical.

Test Plan:
1. N_FRAC=7, mode 00, phase 32, threshold 0, strobe every 4 cycles -> acc 32,64,96,-128,-96,... -> data 127,127,127,-127,-127; each valid exactly 2 cycles after its strobe; data_o stable between pulses.
2. Mode 01, phase 64, 4 back-to-back strobes -> acc 64,-128,-64,0 -> data 64,-127,-64,0 on 4 consecutive valid cycles.
3. Mode 10, phase 64, 4 strobes -> data 0,127,0,-127. Then phase 127 from acc 0 -> 126. Checks triangle saturation and mapping.
4. Sync and mode change:
   - acc=96: sync+strobe with phase 32, mode 00, threshold 0 -> data 127, internal acc 32.
   - sync alone -> no valid.
   - next strobe with phase 32 -> acc 32 -> 127.
   - Switch mode_i to 11 while a sample is in flight -> in-flight sample keeps the old mode; next sample is 0.
5. Async reset: assert rst_i mid-stream between clock edges -> data_o and valid go 0 immediately. After release, no valid until a strobe; first strobe with phase 16 in mode 01 -> 16.
6. With WAVEGEN_OFFSET_EN:
   - Mode 01, acc 96, offset 64 -> 127.
   - Acc -128, offset -64 -> -127.
   - Mode 11, offset -20 -> -20.
